// File: rtl/uart_pkg.sv
`timescale 1ns/1ps
// Shared types and default sizing for the UART transmit path.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package uart_pkg;

  // Default frame geometry and baud-divisor width
  localparam int SIZE_DATA_DEF   = 8;
  localparam int OVER_SAMPLE_DEF = 16;
  localparam int SIZE_BAUD_DEF   = 24;

  // Transmit FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

endpackage : uart_pkg

// File: rtl/uart_baud_tick.sv
`timescale 1ns/1ps
// Free-running baud tick generator: one-cycle o_stick every i_baud_rate clocks.
// Latency: tick is registered, one cycle after the counter reaches i_baud_rate-1.
// Backpressure: none; runs continuously regardless of downstream state.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int SIZE_BAUD = SIZE_BAUD_DEF
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [SIZE_BAUD-1:0] i_baud_rate,
  output logic                 o_stick
);

  logic [SIZE_BAUD-1:0] cnt_q;
  logic [SIZE_BAUD-1:0] cnt_d;
  logic                 stick_q;
  logic                 stick_d;
  logic [SIZE_BAUD-1:0] cnt_last;
  logic                 div_active;

  // Next counter value and tick; divisors 0/1 tick every cycle, and a counter
  // stranded above a newly lowered divisor wraps straight to 0 without a tick.
  always_comb begin
    cnt_last   = i_baud_rate - SIZE_BAUD'(1);
    div_active = (i_baud_rate > SIZE_BAUD'(1));
    cnt_d      = cnt_q + SIZE_BAUD'(1);
    stick_d    = 1'b0;
    if (!div_active) begin
      cnt_d   = '0;
      stick_d = 1'b1;
    end else if (cnt_q == cnt_last) begin
      cnt_d   = '0;
      stick_d = 1'b1;
    end else if (cnt_q > cnt_last) begin
      cnt_d   = '0;
    end
  end

  // Counter and tick registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q   <= '0;
      stick_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      stick_q <= stick_d;
    end
  end

  assign o_stick = stick_q;

endmodule : uart_baud_tick

// File: rtl/uart_tx_core.sv
`timescale 1ns/1ps
// UART transmitter: pops a word from the TX FIFO and serializes start/data(LSB first)/stop.
// Latency: line drops to start bit one cycle after the pop decision; each bit OVER_SAMPLE ticks.
// Backpressure: pulls only in IDLE with i_tx_en && !i_fifo_empty; a frame in flight always completes.
module uart_tx_core
  import uart_pkg::*;
#(
  parameter int SIZE_DATA   = SIZE_DATA_DEF,
  parameter int OVER_SAMPLE = OVER_SAMPLE_DEF,
  parameter int SIZE_BAUD   = SIZE_BAUD_DEF
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [SIZE_BAUD-1:0] i_baud_rate,
  input  logic                 i_tx_en,
  input  logic                 i_fifo_empty,
  input  logic [SIZE_DATA-1:0] i_tx_data,
  output logic                 o_tx_serial,
  output logic                 o_tx_done,
  output logic                 o_valid,
  output logic                 o_stick
);

  localparam int TW = $clog2(OVER_SAMPLE + 1);
  localparam int IW = (SIZE_DATA > 1) ? $clog2(SIZE_DATA) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(OVER_SAMPLE - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(SIZE_DATA - 1);

  tx_state_e            state_q,  state_d;
  logic [TW-1:0]        os_cnt_q, os_cnt_d;
  logic [IW-1:0]        idx_q,    idx_d;
  logic [SIZE_DATA-1:0] shreg_q,  shreg_d;
  logic                 serial_q, serial_d;
  logic                 done_q,   done_d;
  logic                 valid_q,  valid_d;
  logic                 stick;
  logic                 bit_end;

  uart_baud_tick #(
    .SIZE_BAUD (SIZE_BAUD)
  ) u_baud_tick (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_baud_rate (i_baud_rate),
    .o_stick     (stick)
  );

  // Next-state, bit timing and registered-output decode for the transmit FSM
  always_comb begin
    state_d  = state_q;
    os_cnt_d = os_cnt_q;
    idx_d    = idx_q;
    shreg_d  = shreg_q;
    done_d   = 1'b0;
    valid_d  = 1'b0;
    serial_d = 1'b1;
    bit_end  = stick && (os_cnt_q == TICK_LAST);

    case (state_q)
      IDLE: begin
        if (i_tx_en && !i_fifo_empty) begin
          shreg_d  = i_tx_data;
          valid_d  = 1'b1;
          os_cnt_d = '0;
          idx_d    = '0;
          state_d  = START;
        end
      end
      START: begin
        if (bit_end) begin
          os_cnt_d = '0;
          idx_d    = '0;
          state_d  = DATA;
        end else if (stick) begin
          os_cnt_d = os_cnt_q + TW'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          os_cnt_d = '0;
          if (idx_q == IDX_LAST) begin
            state_d = STOP;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end else if (stick) begin
          os_cnt_d = os_cnt_q + TW'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          os_cnt_d = '0;
          done_d   = 1'b1;
          state_d  = IDLE;
        end else if (stick) begin
          os_cnt_d = os_cnt_q + TW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Line level follows the state being entered so it is registered with it
    case (state_d)
      START:   serial_d = 1'b0;
      DATA:    serial_d = shreg_d[idx_d];
      default: serial_d = 1'b1;
    endcase
  end

  // FSM, shift register and output registers; reset parks the line high
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      os_cnt_q <= '0;
      idx_q    <= '0;
      shreg_q  <= '0;
      serial_q <= 1'b1;
      done_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      os_cnt_q <= os_cnt_d;
      idx_q    <= idx_d;
      shreg_q  <= shreg_d;
      serial_q <= serial_d;
      done_q   <= done_d;
      valid_q  <= valid_d;
    end
  end

  assign o_tx_serial = serial_q;
  assign o_tx_done   = done_q;
  assign o_valid     = valid_q;
  assign o_stick     = stick;

endmodule : uart_tx_core

// File: tb/tb_uart_tx_core.sv
`timescale 1ns/1ps
// Self-checking bench for uart_tx_core against a frame-level reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_tx_core;

  localparam int OS = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] baud = 24'd4;
  logic        tx_en = 1'b0;
  logic        fifo_empty = 1'b1;
  logic [7:0]  tx_data = 8'h00;
  logic        tx_serial;
  logic        tx_done;
  logic        valid;
  logic        stick;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] fifo_q[$];

  always #10 clk = ~clk;

  uart_tx_core dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_baud_rate  (baud),
    .i_tx_en      (tx_en),
    .i_fifo_empty (fifo_empty),
    .i_tx_data    (tx_data),
    .o_tx_serial  (tx_serial),
    .o_tx_done    (tx_done),
    .o_valid      (valid),
    .o_stick      (stick)
  );

  // Drive FIFO head/empty from the model queue
  task automatic present_head();
    if (fifo_q.size() > 0) begin
      fifo_empty = 1'b0;
      tx_data    = fifo_q[0];
    end else begin
      fifo_empty = 1'b1;
    end
  endtask

  // Wait for a pop, then record the line every cycle up to o_tx_done and
  // compare with the ideal frame: start 0, data LSB first, stop 1.
  task automatic capture_frame(input int b, input int max_wait, input bit mid_change,
                               input string name);
    bit         got;
    bit         done_seen;
    bit         tr[$];
    logic [7:0] exp;
    int         extra_valid;
    int         overlap;
    int         l0;
    int         bad;
    int         k;
    bit         e;
    got = 0; done_seen = 0; extra_valid = 0; overlap = 0; bad = 0;
    for (int i = 0; i < max_wait; i++) begin
      @(negedge clk);
      if (valid) begin
        got = 1;
        break;
      end
    end
    vectors++;
    if (!got) begin
      miscompares++;
      $display("FAIL %s_pop: o_valid not seen within %0d cycles, required 1 pulse", name, max_wait);
      return;
    end
    exp = (fifo_q.size() > 0) ? fifo_q.pop_front() : 8'h00;
    present_head();
    tr.push_back(tx_serial);
    for (int i = 0; i < 10 * OS * b + 40; i++) begin
      @(negedge clk);
      if (mid_change && tr.size() == OS * b * 4) begin
        tx_data = ~tx_data;
        tx_en   = 1'b0;
      end
      if (valid) extra_valid++;
      if (valid && tx_done) overlap++;
      tr.push_back(tx_serial);
      if (tx_done) begin
        done_seen = 1;
        break;
      end
    end
    vectors++;
    if (!done_seen || extra_valid != 0 || overlap != 0) begin
      miscompares++;
      $display("FAIL %s_handshake: done=%0d extra_pops=%0d overlap=%0d, required 1/0/0",
               name, done_seen, extra_valid, overlap);
      return;
    end
    l0 = tr.size() - 1 - 9 * OS * b;
    vectors++;
    if (l0 < (OS - 1) * b + 1 || l0 > OS * b) begin
      miscompares++;
      $display("FAIL %s_start_len: got %0d cycles, required %0d..%0d",
               name, l0, (OS - 1) * b + 1, OS * b);
      return;
    end
    for (int i = 0; i < tr.size(); i++) begin
      if (i < l0) begin
        e = 1'b0;
      end else begin
        k = (i - l0) / (OS * b);
        e = (k < 8) ? exp[k] : 1'b1;
      end
      if (tr[i] != e) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL %s_bits: %0d wrong line samples for data 0x%02h, required 0", name, bad, exp);
    end
  endtask

  task automatic test_reset();
    int bad;
    bad = 0;
    rst_n = 1'b0;
    baud  = 24'd4;
    tx_en = 1'b1;
    fifo_q.push_back(8'h55);
    present_head();
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (tx_serial !== 1'b1 || valid !== 1'b0 || tx_done !== 1'b0 || stick !== 1'b0) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL reset_hold: %0d cycles with active outputs, required 0", bad);
    end
    vectors++;
    if (tx_serial !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_line: got %b, required 1", tx_serial);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single_frame();
    capture_frame(4, 4, 0, "frame_55");
  endtask

  task automatic test_random_frames();
    int b;
    for (int n = 0; n < 4; n++) begin
      b = $urandom_range(1, 5);
      @(negedge clk);
      baud = 24'(b);
      fifo_q.push_back(8'($urandom));
      present_head();
      tx_en = 1'b1;
      capture_frame(b, 8, 0, $sformatf("rand%0d", n));
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    baud = 24'd4;
    fifo_q.push_back(8'hA5);
    fifo_q.push_back(8'h3C);
    fifo_q.push_back(8'($urandom));
    present_head();
    tx_en = 1'b1;
    capture_frame(4, 8, 0, "b2b_first");
    capture_frame(4, 2, 0, "b2b_second");
    capture_frame(4, 2, 0, "b2b_third");
  endtask

  task automatic test_idle_hold();
    int bad;
    bad = 0;
    fifo_q.delete();
    present_head();
    tx_en = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (tx_serial !== 1'b1 || valid !== 1'b0 || tx_done !== 1'b0) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL idle_empty: %0d active cycles, required 0", bad);
    end
    bad = 0;
    tx_en = 1'b0;
    fifo_q.push_back(8'($urandom));
    present_head();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (tx_serial !== 1'b1 || valid !== 1'b0 || tx_done !== 1'b0) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL idle_disabled: %0d active cycles, required 0", bad);
    end
    fifo_q.delete();
    present_head();
  endtask

  task automatic test_mid_change();
    int bad;
    bad = 0;
    @(negedge clk);
    baud = 24'd3;
    fifo_q.push_back(8'($urandom));
    fifo_q.push_back(8'($urandom));
    present_head();
    tx_en = 1'b1;
    capture_frame(3, 8, 1, "midchg");
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (valid !== 1'b0 || tx_serial !== 1'b1) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL midchg_no_restart: %0d active cycles, required 0", bad);
    end
    fifo_q.delete();
    present_head();
  endtask

  task automatic test_reset_mid_frame();
    bit got;
    got = 0;
    @(negedge clk);
    baud = 24'd4;
    fifo_q.push_back(8'h00);
    present_head();
    tx_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (valid) begin
        got = 1;
        break;
      end
    end
    void'(fifo_q.pop_front());
    present_head();
    tx_en = 1'b0;
    vectors++;
    if (!got) begin
      miscompares++;
      $display("FAIL rstmid_pop: o_valid not seen, required 1 pulse");
    end
    repeat (OS * 4 * 3) @(negedge clk);
    vectors++;
    if (tx_serial !== 1'b0) begin
      miscompares++;
      $display("FAIL rstmid_pre_line: got %b, required 0", tx_serial);
    end
    #3 rst_n = 1'b0;
    #1;
    vectors++;
    if (tx_serial !== 1'b1) begin
      miscompares++;
      $display("FAIL rstmid_async_line: got %b, required 1", tx_serial);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    fifo_q.push_back(8'($urandom));
    present_head();
    tx_en = 1'b1;
    capture_frame(4, 8, 0, "post_reset");
    tx_en = 1'b0;
  endtask

  task automatic test_stick();
    bit got;
    int period;
    int gap;
    int bad;
    @(negedge clk);
    baud = 24'd325;
    for (int p = 0; p < 2; p++) begin
      got = 0;
      period = -1;
      for (int i = 0; i < 400; i++) begin
        @(negedge clk);
        if (stick) begin
          got = 1;
          break;
        end
      end
      if (got) begin
        for (int i = 1; i <= 400; i++) begin
          @(negedge clk);
          if (stick) begin
            period = i;
            break;
          end
        end
      end
      vectors++;
      if (period != 325) begin
        miscompares++;
        $display("FAIL stick_period%0d: got %0d cycles, required 325", p, period);
      end
    end
    // Lowering the divisor below the live count must wrap, not wait a full old period
    repeat (200) @(negedge clk);
    baud = 24'd50;
    gap = -1;
    for (int i = 1; i <= 400; i++) begin
      @(negedge clk);
      if (stick) begin
        gap = i;
        break;
      end
    end
    vectors++;
    if (gap < 49 || gap > 52) begin
      miscompares++;
      $display("FAIL stick_shrink: first tick after %0d cycles, required 49..52", gap);
    end
    baud = 24'd1;
    repeat (2) @(negedge clk);
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (stick !== 1'b1) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL stick_div1: %0d cycles without tick, required 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_random_frames();
    test_back_to_back();
    test_idle_hold();
    test_mid_change();
    test_reset_mid_frame();
    test_stick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_uart_tx_core

// File: doc/uart_tx_core.md
Name: uart_tx_core

Overview:
- UART transmit engine with an integrated programmable baud-tick generator.
- Pulls one SIZE_DATA-bit word from an upstream FIFO when enabled and non-empty, then serializes it as 8N1-style frames: start 0, data LSB-first, one stop 1.
- Each bit lasts OVER_SAMPLE baud ticks.
- Sits between the TX FIFO and the serial pin.

Parameters:
- SIZE_DATA, 8: data bits per frame.
- OVER_SAMPLE, 16: baud ticks per serial bit.
- SIZE_BAUD, 24: width of the baud divisor input.

Ports:
- i_clk  in  1  system clock (50 MHz nominal).
- i_rst_n  in  1  reset, asynchronous and active-low.
- i_baud_rate  in  SIZE_BAUD  tick divisor, in clock cycles per tick (325 gives ~9600 baud x16 at 50 MHz).
- i_tx_en  in  1  transmit enable (level).
- i_fifo_empty  in  1  upstream FIFO empty flag.
- i_tx_data  in  SIZE_DATA  word at FIFO head.
- o_tx_serial  out  1  serial line, idle high.
- o_tx_done  out  1  one-cycle pulse when a stop bit completes.
- o_valid  out  1  one-cycle FIFO pop strobe; marks the cycle i_tx_data is latched.
- o_stick  out  1  baud tick, exported for debug and sharing.

Behaviour:
Reset values:
- o_tx_serial=1, o_tx_done=0, o_valid=0, o_stick=0.
- Tick counter 0, FSM IDLE.
- Reset asserted mid-frame aborts the frame immediately and drives the line high.

Tick generator:
- Counter runs 0..i_baud_rate-1.
- o_stick=1 for exactly one cycle when counter==i_baud_rate-1, then the counter wraps to 0. Period = i_baud_rate cycles.
- i_baud_rate of 0 or 1 gives a tick every cycle.
- If i_baud_rate changes so that counter>=new value, the counter wraps to 0 on the next cycle.
- The generator free-runs and is independent of FSM state.

FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - Line 1.
  - If i_tx_en && !i_fifo_empty: latch i_tx_data into a shift register, pulse o_valid that cycle, go to START.
  - Otherwise stay.
- START:
  - Line 0.
  - Count ticks; after OVER_SAMPLE ticks go to DATA with bit index 0.
- DATA:
  - Line = shift_reg[index], LSB first.
  - After OVER_SAMPLE ticks, advance index.
  - After bit SIZE_DATA-1 completes, go to STOP.
- STOP:
  - Line 1.
  - After OVER_SAMPLE ticks: pulse o_tx_done one cycle, return to IDLE.

Timing and boundary rules:
- The tick counter inside the FSM resets to 0 on every state/bit transition.
- The first bit may be up to one tick period short because the tick phase is free-running; this is acceptable.
- o_tx_serial is registered (glitch-free).
- Back-to-back frames: a new frame may start on the cycle after o_tx_done if enable and non-empty still hold. At most one extra idle-high cycle between frames.
- i_tx_data and i_tx_en changes mid-frame have no effect; the frame always completes.
- i_fifo_empty is sampled only in IDLE.
- o_valid and o_tx_done are never high in the same cycle.

Decomposition:
- Shared package uart_pkg: FSM state enum (IDLE/START/DATA/STOP), default SIZE_DATA/OVER_SAMPLE/SIZE_BAUD constants.
- One sub-module, uart_baud_tick: tick generator (i_clk, i_rst_n, i_baud_rate, o_stick).
- FSM and shift register stay in the top.

Test Plan:
1. Reset held 1000 cycles with i_tx_en=1 and data present -> o_tx_serial=1, o_valid=0, o_tx_done=0 throughout; no o_stick.
2. i_baud_rate=4, i_tx_en=1, i_fifo_empty=0, i_tx_data=0x55 -> o_valid pulses once; line shows 0,1,0,1,0,1,0,1,0,1 (start, LSB-first data, stop), each bit 64 cycles (first may be up to 3 short); one o_tx_done pulse after the stop bit.
3. Hold enable with FIFO non-empty, data 0xA5 then 0x3C -> two consecutive frames, second o_valid within 1 cycle after the first o_tx_done; bits match LSB-first.
4. i_fifo_empty=1 with i_tx_en=1 (or i_tx_en=0 with data) -> line stays high, no o_valid, no o_tx_done.
5. Mid-DATA: change i_tx_data and drop i_tx_en -> frame completes with the originally latched bits; no new frame starts.
6. Reset asserted mid-DATA -> line high immediately (asynchronous); after release, FSM is IDLE and the next frame is well-formed. Also check o_stick period = 325 cycles with i_baud_rate=325.
